ad_frame_capture: RTL and testbench

- Parametrised ADC front-end capture block in the clk_50m domain.
- Replaces the family of separately derived sample clocks (640k/256k/1M) with one clk_50m and a selectable clock-enable divider. Also drives the ADC sample clock pin.
- Captures one trigger-aligned frame of DEPTH samples into internal RAM, then streams it to the FFT/THD path over a valid/ready interface.

---
 rtl/ad_pkg.sv | 39 +++
 rtl/ad_frame_capture_rate_div.sv | 42 ++++
 rtl/ad_frame_capture.sv | 135 +++++++++++++
 tb/tb_ad_frame_capture.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ad_pkg.sv
// Shared state type and sizing helpers for the ADC frame capture block.
package ad_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_e;

  function automatic int div_sel(input logic [1:0] sel, input int d0, input int d1,
                                 input int d2, input int d3);
    case (sel)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  // Counter width must also hold the divide value itself.
  function automatic int cnt_w(input int d0, input int d1, input int d2, input int d3);
    int m;
    m = d0;
    if (d1 > m) m = d1;
    if (d2 > m) m = d2;
    if (d3 > m) m = d3;
    return $clog2(m + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int to_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ad_frame_capture_rate_div.sv
// Sample-rate divider: one-cycle sample_en at the end of each period and a
// registered ADC clock that is high for the first half of the period.
module ad_rate_div #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             sample_en_o,
  output logic             ad_clk_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_c;
  logic             run_q, ad_clk_q, ad_clk_d;

  assign last_c = div_i - CNT_W'(1);

  always_comb begin
    cnt_d = '0;
    if (run_i && run_q && !restart_i)
      cnt_d = (cnt_q == last_c) ? '0 : cnt_q + CNT_W'(1);
    ad_clk_d = run_i && (cnt_d < (div_i >> 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      ad_clk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_i;
      ad_clk_q <= ad_clk_d;
    end
  end

  assign sample_en_o = run_q && (cnt_q == last_c);
  assign ad_clk_o    = ad_clk_q;

endmodule

// File: rtl/ad_frame_capture.sv
// Captures one trigger-aligned frame of DEPTH ADC samples and streams it out on
// valid/ready; first m_valid 2 cycles into readout, stalls hold m_data/m_last.
module ad_frame_capture
  import ad_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int DIV0         = 78,
  parameter int DIV1         = 195,
  parameter int DIV2         = 50,
  parameter int DIV3         = 5,
  parameter int TRIG_TIMEOUT = 4096,
  parameter bit SIGNED_OUT   = 1'b1
) (
  input  logic              clk_50m,
  input  logic              reset,
  input  logic [DATA_W-1:0] ad_data,
  output logic              ad_clk,
  input  logic [1:0]        rate_sel,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              start,
  output logic              busy,
  output logic              trig_forced,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CNT_W  = cnt_w(DIV0, DIV1, DIV2, DIV3);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int TO_W   = to_w(TRIG_TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] OUT_FLIP  = SIGNED_OUT ? (DATA_W'(1) << (DATA_W - 1)) : '0;

  state_e            state_q, state_d;
  logic [1:0]        rate_q, rate_d;
  logic [DATA_W-1:0] lvl_q, lvl_d, prev_q, prev_d, m_data_q, m_data_d, ram_q;
  logic              first_q, first_d, forced_q, forced_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, waddr;
  logic              rd_done_q, rd_done_d, s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic              we, re, hit, adv, accept, sample_en;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign accept = (state_q == S_IDLE) && start;
  // Output register advances whenever it is empty or being drained.
  assign adv    = !m_valid_q || m_ready;

  ad_rate_div #(.CNT_W(CNT_W)) u_div (
    .clk_i       (clk_50m),
    .rst_i       (reset),
    .run_i       (state_d != S_IDLE),
    .restart_i   (accept),
    .div_i       (CNT_W'(div_sel(rate_d, DIV0, DIV1, DIV2, DIV3))),
    .sample_en_o (sample_en),
    .ad_clk_o    (ad_clk)
  );

  always_comb begin
    state_d = state_q;     rate_d    = rate_q;     lvl_d     = lvl_q;
    prev_d  = prev_q;      first_d   = first_q;    to_d      = to_q;
    forced_d = forced_q;   wr_addr_d = wr_addr_q;  rd_addr_d = rd_addr_q;
    rd_done_d = rd_done_q; s1_vld_d  = s1_vld_q;   s1_last_d = s1_last_q;
    m_valid_d = m_valid_q; m_last_d  = m_last_q;   m_data_d  = m_data_q;
    we = 1'b0; re = 1'b0; hit = 1'b0; waddr = wr_addr_q;
    case (state_q)
      S_IDLE: if (start) begin
        rate_d = rate_sel; lvl_d = trig_level; forced_d = 1'b0;
        prev_d = '0; first_d = 1'b1; to_d = '0; wr_addr_d = '0;
        state_d = trig_en ? S_ARM : S_CAPTURE;
      end
      S_ARM: if (sample_en) begin
        hit = !first_q && (prev_q < lvl_q) && (ad_data >= lvl_q);
        if (hit || (to_q == TO_LAST)) begin
          forced_d = !hit; we = 1'b1; waddr = '0;
          wr_addr_d = ADDR_W'(1); state_d = S_CAPTURE;
        end else begin
          prev_d = ad_data; first_d = 1'b0; to_d = to_q + TO_W'(1);
        end
      end
      S_CAPTURE: if (sample_en) begin
        we = 1'b1; wr_addr_d = wr_addr_q + ADDR_W'(1);
        if (wr_addr_q == ADDR_LAST) begin
          state_d = S_READOUT; rd_addr_d = '0; rd_done_d = 1'b0; s1_vld_d = 1'b0;
        end
      end
      default: begin
        // Stage 1 holds the RAM read result; refill it whenever it empties.
        re = !rd_done_q && (!s1_vld_q || adv);
        if (adv) begin
          m_valid_d = s1_vld_q;
          m_last_d  = s1_vld_q && s1_last_q;
          if (s1_vld_q) m_data_d = ram_q ^ OUT_FLIP;
          s1_vld_d = 1'b0;
        end
        if (re) begin
          s1_vld_d = 1'b1; s1_last_d = (rd_addr_q == ADDR_LAST);
          rd_done_d = (rd_addr_q == ADDR_LAST); rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (m_valid_q && m_ready && m_last_q) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  rate_q <= '0;      lvl_q <= '0;      prev_q <= '0;
      first_q <= 1'b0;    to_q <= '0;        forced_q <= 1'b0; wr_addr_q <= '0;
      rd_addr_q <= '0;    rd_done_q <= 1'b0; s1_vld_q <= 1'b0; s1_last_q <= 1'b0;
      m_valid_q <= 1'b0;  m_last_q <= 1'b0;  m_data_q <= '0;
    end else begin
      state_q <= state_d;     rate_q <= rate_d;       lvl_q <= lvl_d;
      prev_q <= prev_d;       first_q <= first_d;     to_q <= to_d;
      forced_q <= forced_d;   wr_addr_q <= wr_addr_d; rd_addr_q <= rd_addr_d;
      rd_done_q <= rd_done_d; s1_vld_q <= s1_vld_d;   s1_last_q <= s1_last_d;
      m_valid_q <= m_valid_d; m_last_q <= m_last_d;   m_data_q <= m_data_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (we) mem_q[waddr] <= ad_data;
    if (re) ram_q <= mem_q[rd_addr_q];
  end

  assign busy        = (state_q != S_IDLE);
  assign trig_forced = forced_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;

endmodule

// File: tb/tb_ad_frame_capture.sv
// Directed bench for ad_frame_capture: an ADC stream model records every sample
// period, and a frame model derives the expected output sequence from it.
module tb_ad_frame_capture;

  localparam int DW    = 10;
  localparam int DEPTH = 64;
  localparam int TMO   = 128;

  logic          clk_50m = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] ad_data = '0;
  logic          ad_clk;
  logic [1:0]    rate_sel = '0;
  logic          trig_en = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          start = 1'b0;
  logic          busy, trig_forced, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  int n_tests = 0, n_fail = 0;
  int gen_mode = 0, k = 0, rx_cnt = 0, ready_mode = 0, m_lvl = 0;
  int hist[$];
  logic          m_trig_en = 1'b0;
  logic [DW-1:0] first_dat = '0, last_dat = '0;

  ad_frame_capture #(
    .DATA_W(DW), .DEPTH(DEPTH), .DIV0(78), .DIV1(195), .DIV2(10), .DIV3(5),
    .TRIG_TIMEOUT(TMO), .SIGNED_OUT(1'b1)
  ) dut (
    .clk_50m(clk_50m), .reset(reset), .ad_data(ad_data), .ad_clk(ad_clk),
    .rate_sel(rate_sel), .trig_en(trig_en), .trig_level(trig_level), .start(start),
    .busy(busy), .trig_forced(trig_forced), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int gen(input int idx);
    case (gen_mode)
      0:       return idx % 1024;
      1:       return 512 + $rtoi($floor(500.0 * $cos(2.0 * 3.14159265358979 * idx / 100.0) + 0.5));
      default: return 100;
    endcase
  endfunction

  // Index of the first rising crossing of the sample stream, -1 if none in the window.
  function automatic int find_cross();
    for (int j = 1; j < TMO; j++)
      if (hist[j-1] < m_lvl && hist[j] >= m_lvl) return j;
    return -1;
  endfunction

  function automatic int model_start();
    if (!m_trig_en) return 0;
    return (find_cross() < 0) ? TMO - 1 : find_cross();
  endfunction

  function automatic logic model_forced();
    return m_trig_en && (find_cross() < 0);
  endfunction

  // ADC model: a new value appears just after each ad_clk rise and holds for the period.
  initial forever begin
    @(posedge ad_clk);
    #2;
    ad_data = DW'(gen(k));
    hist.push_back(gen(k));
    k++;
  end

  // Output checker: drives m_ready for the coming edge, then judges that edge's transfer.
  initial begin : cmp
    logic          stall_pend, busy_chk;
    logic [DW+1:0] stall_word;
    int            raw;
    stall_pend = 1'b0; busy_chk = 1'b0; stall_word = '0;
    forever begin
      @(negedge clk_50m);
      m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      if (reset) begin
        stall_pend = 1'b0; busy_chk = 1'b0;
      end else begin
        if (busy_chk) begin
          check("busy_fall", busy, 0);
          check("valid_after_last", m_valid, 0);
          busy_chk = 1'b0;
        end
        if (stall_pend) check("stall_hold", {m_valid, m_last, m_data}, stall_word);
        if (m_valid && m_ready) begin
          raw = hist[model_start() + rx_cnt];
          check("m_data", m_data, DW'(raw) ^ 10'h200);
          check("m_last", m_last, rx_cnt == DEPTH - 1);
          if (rx_cnt == 0) first_dat = m_data;
          last_dat = m_data;
          if (m_last) begin
            check("busy_at_last", busy, 1);
            busy_chk = 1'b1;
          end
          rx_cnt++;
        end
        stall_pend = m_valid && !m_ready;
        stall_word = {m_valid, m_last, m_data};
      end
    end
  end

  task automatic run_frame(input logic [1:0] rs, input logic te, input int lvl, input int mode,
                           input int rdy, input int exp_per, input int exp_hi, input bit poke,
                           input bit abort, input int stop_rx);
    int r1, r2, f1, c;
    logic pv;
    gen_mode = mode; hist.delete(); k = 0; rx_cnt = 0;
    m_trig_en = te; m_lvl = lvl; ready_mode = rdy;
    rate_sel = rs; trig_en = te; trig_level = DW'(lvl); start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0; rate_sel = ~rs;
    if (exp_per > 0) begin
      r1 = -1; r2 = -1; f1 = -1; pv = 1'b0;
      for (int i = 0; i < 3 * exp_per; i++) begin
        if (ad_clk && !pv) begin
          if (r1 < 0) r1 = i;
          else if (r2 < 0) r2 = i;
        end
        if (!ad_clk && pv && f1 < 0) f1 = i;
        pv = ad_clk;
        @(negedge clk_50m);
      end
      check("adclk_period", r2 - r1, exp_per);
      check("adclk_high", f1 - r1, exp_hi);
    end
    if (poke) begin
      repeat (30) @(negedge clk_50m);
      start = 1'b1; trig_en = 1'b1; rate_sel = 2'd0; trig_level = 10'h3ff;
      @(negedge clk_50m);
      start = 1'b0;
    end
    if (stop_rx > 0) begin
      c = 0;
      while (rx_cnt < stop_rx && c < 5000) begin @(negedge clk_50m); c++; end
      check("reach_readout", rx_cnt >= stop_rx, 1);
    end
    if (!abort) begin
      c = 0;
      while (busy && c < 5000) begin @(negedge clk_50m); c++; end
      check("frame_done", busy, 0);
      check("rx_count", rx_cnt, DEPTH);
      check("trig_forced", trig_forced, model_forced());
    end
  endtask

  task automatic pulse_reset(input string name);
    #3 reset = 1'b1;
    #1 check(name, {ad_clk, busy, m_valid, m_last, trig_forced, m_data}, 0);
    repeat (3) @(negedge clk_50m);
    reset = 1'b0;
    @(negedge clk_50m);
  endtask

  initial begin : main
    int hi;
    repeat (50) @(negedge clk_50m);
    reset = 1'b0;
    @(negedge clk_50m);
    check("reset_outs", {ad_clk, busy, m_valid, m_last, trig_forced, m_data}, 0);
    hi = 0;
    repeat (40) begin @(negedge clk_50m); hi += int'(ad_clk); end
    check("idle_adclk", hi, 0);

    // Slow rate: divider shape only, then abort with reset.
    run_frame(2'd1, 1'b0, 0, 0, 0, 195, 97, 1'b0, 1'b1, 0);
    pulse_reset("abort_capture_outs");

    // Ramp at 10 MHz, always ready.
    run_frame(2'd3, 1'b0, 0, 0, 0, 5, 2, 1'b0, 1'b0, 0);
    check("ramp_first", first_dat, 10'h200);
    check("ramp_last", last_dat, 10'h23f);

    // Sine trigger on rising crossing of 512.
    run_frame(2'd2, 1'b1, 512, 1, 0, 0, 0, 1'b0, 1'b0, 0);
    check("trig_index", model_start(), 75);
    check("trig_first", first_dat, 10'h000);
    check("trig_not_forced", trig_forced, 0);

    // Constant input never crosses: forced trigger.
    run_frame(2'd3, 1'b1, 512, 2, 0, 0, 0, 1'b0, 1'b0, 0);
    check("timeout_forced", trig_forced, 1);
    check("timeout_first", first_dat, 10'h264);

    // Random backpressure plus an ignored start mid-capture.
    run_frame(2'd3, 1'b0, 0, 0, 1, 0, 0, 1'b1, 1'b0, 0);

    // Reset during readout, then a clean frame.
    run_frame(2'd3, 1'b0, 0, 0, 1, 0, 0, 1'b0, 1'b1, 5);
    pulse_reset("abort_readout_outs");
    run_frame(2'd3, 1'b0, 0, 0, 1, 0, 0, 1'b0, 1'b0, 0);
    check("post_reset_last", last_dat, 10'h23f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
